mult_commute_checker: RTL and testbench

MULT_COMMUTE_CHECKER -- requirements
Module: mult_commute_checker

---
 rtl/mult_commute_checker.sv | 149 ++++++++++++++
 tb/tb_mult_commute_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_commute_checker.sv
// Commutativity checker: two shift-add multiplier lanes compute a*b and b*a
// in parallel; their products and cycle counts are compared and errors tallied.

module ShiftAddLane #(
  parameter int WIDTH      = 4,
  parameter int CONST_TIME = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   mplierIn,
  input  logic [WIDTH-1:0]   mcandIn,
  output logic [2*WIDTH-1:0] acc,
  output logic [WIDTH:0]     count,
  output logic               busy
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               lastCycle;

  // Early-exit lanes stop once the bits still to be consumed are all zero.
  always_comb begin
    lastCycle = 1'b0;
    if (CONST_TIME != 0)
      lastCycle = (count == (WIDTH+1)'(WIDTH-1));
    else
      lastCycle = (mplier[WIDTH-1:1] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, mcandIn};
      mplier <= mplierIn;
      count  <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0])
        acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (lastCycle)
        busy <= 1'b0;
    end
  end

endmodule

module mult_commute_checker #(
  parameter int WIDTH      = 4,
  parameter int CONST_TIME = 1,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               fault_inj,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH:0]     cycles_a,
  output logic [WIDTH:0]     cycles_b,
  output logic               commute_err,
  output logic               timing_err,
  output logic [CNT_W-1:0]   err_count
);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} stateT;

  stateT              state;
  logic               laneLoad;
  logic               faultReg;
  logic [2*WIDTH-1:0] accA, accB, prodB;
  logic [WIDTH:0]     cntA, cntB;
  logic               busyA, busyB;
  logic               prodDiff, timeDiff;

  assign laneLoad = (state == IDLE) && start;
  assign prodB    = accB ^ (2*WIDTH)'(faultReg);
  assign prodDiff = (accA != prodB);
  assign timeDiff = (cntA != cntB);

  ShiftAddLane #(.WIDTH(WIDTH), .CONST_TIME(CONST_TIME)) laneA (
    .clk(clk), .rst(rst), .load(laneLoad), .mplierIn(a), .mcandIn(b),
    .acc(accA), .count(cntA), .busy(busyA)
  );

  ShiftAddLane #(.WIDTH(WIDTH), .CONST_TIME(CONST_TIME)) laneB (
    .clk(clk), .rst(rst), .load(laneLoad), .mplierIn(b), .mcandIn(a),
    .acc(accB), .count(cntB), .busy(busyB)
  );

  // RUN waits one cycle after both lanes go idle, then latches the results into REPORT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      product     <= '0;
      cycles_a    <= '0;
      cycles_b    <= '0;
      commute_err <= 1'b0;
      timing_err  <= 1'b0;
      err_count   <= '0;
      faultReg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            ready    <= 1'b0;
            faultReg <= fault_inj;
          end
        end
        RUN: begin
          if (!busyA && !busyB) begin
            state       <= REPORT;
            done        <= 1'b1;
            product     <= accA;
            cycles_a    <= cntA;
            cycles_b    <= cntB;
            commute_err <= prodDiff;
            timing_err  <= timeDiff;
            if ((prodDiff || timeDiff) && (err_count != '1))
              err_count <= err_count + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          ready       <= 1'b1;
          done        <= 1'b0;
          commute_err <= 1'b0;
          timing_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_commute_checker.sv
// Directed bench for mult_commute_checker: constant-time, early-exit and
// small-counter instances driven with hand-computed vectors.

module tb_mult_commute_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0, b = '0;
  logic       fault_inj = 1'b0;
  logic       startC = 1'b0, startE = 1'b0, startS = 1'b0;

  logic       readyC, doneC, commC, timeC;
  logic [7:0] prodC, errCntC;
  logic [4:0] caC, cbC;
  logic       readyE, doneE, commE, timeE;
  logic [7:0] prodE, errCntE;
  logic [4:0] caE, cbE;
  logic       readyS, doneS, commS, timeS;
  logic [7:0] prodS;
  logic [1:0] errCntS;
  logic [4:0] caS, cbS;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_commute_checker #(.WIDTH(4), .CONST_TIME(1), .CNT_W(8)) dutC (
    .clk(clk), .rst(rst), .start(startC), .a(a), .b(b), .fault_inj(fault_inj),
    .ready(readyC), .done(doneC), .product(prodC), .cycles_a(caC), .cycles_b(cbC),
    .commute_err(commC), .timing_err(timeC), .err_count(errCntC)
  );

  mult_commute_checker #(.WIDTH(4), .CONST_TIME(0), .CNT_W(8)) dutE (
    .clk(clk), .rst(rst), .start(startE), .a(a), .b(b), .fault_inj(fault_inj),
    .ready(readyE), .done(doneE), .product(prodE), .cycles_a(caE), .cycles_b(cbE),
    .commute_err(commE), .timing_err(timeE), .err_count(errCntE)
  );

  mult_commute_checker #(.WIDTH(4), .CONST_TIME(1), .CNT_W(2)) dutS (
    .clk(clk), .rst(rst), .start(startS), .a(a), .b(b), .fault_inj(fault_inj),
    .ready(readyS), .done(doneS), .product(prodS), .cycles_a(caS), .cycles_b(cbS),
    .commute_err(commS), .timing_err(timeS), .err_count(errCntS)
  );

  // Drives one accept on the selected instance; returns just after the accept edge.
  task automatic applyStimulus(input int sel, input logic [3:0] va, input logic [3:0] vb,
                               input logic flt);
    a = va; b = vb; fault_inj = flt;
    case (sel)
      0: startC = 1'b1;
      1: startE = 1'b1;
      default: startS = 1'b1;
    endcase
    @(posedge clk); #1;
    startC = 1'b0; startE = 1'b0; startS = 1'b0;
  endtask

  // Counts edges until done on the selected instance; 0 means the bound expired.
  task automatic waitDone(input int sel, output int edges);
    logic d;
    edges = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      case (sel)
        0: d = doneC;
        1: d = doneE;
        default: d = doneS;
      endcase
      if (d) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (readyC !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", readyC); end
    checks++; if (doneC !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", doneC); end
    checks++; if (prodC !== 8'd0 || caC !== 5'd0 || cbC !== 5'd0) begin errors++; $display("[TB] FAIL reset_outputs prod=%0d ca=%0d cb=%0d exp=0", prodC, caC, cbC); end
    checks++; if (errCntC !== 8'd0 || commC !== 1'b0 || timeC !== 1'b0) begin errors++; $display("[TB] FAIL reset_errs cnt=%0d comm=%b time=%b exp=0", errCntC, commC, timeC); end
    rst = 1'b0;
    a = 4'd1; b = 4'd1; startC = 1'b1;
    @(posedge clk); #1;
    startC = 1'b0;
    checks++; if (readyC !== 1'b0) begin errors++; $display("[TB] FAIL first_accept ready got=%b exp=0", readyC); end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_const_time();
    int e;
    applyStimulus(0, 4'd3, 4'd5, 1'b0);
    waitDone(0, e);
    checks++; if (e !== 5) begin errors++; $display("[TB] FAIL const_latency got=%0d exp=5", e); end
    checks++; if (prodC !== 8'd15) begin errors++; $display("[TB] FAIL const_product got=%0d exp=15", prodC); end
    checks++; if (caC !== 5'd4 || cbC !== 5'd4) begin errors++; $display("[TB] FAIL const_cycles got=%0d/%0d exp=4/4", caC, cbC); end
    checks++; if (commC !== 1'b0 || timeC !== 1'b0 || errCntC !== 8'd0) begin errors++; $display("[TB] FAIL const_errs comm=%b time=%b cnt=%0d exp=0/0/0", commC, timeC, errCntC); end
    @(posedge clk); #1;
    checks++; if (readyC !== 1'b1 || doneC !== 1'b0) begin errors++; $display("[TB] FAIL const_after ready=%b done=%b exp=1/0", readyC, doneC); end
  endtask

  task automatic test_early_exit();
    int e;
    applyStimulus(1, 4'd1, 4'd8, 1'b0);
    waitDone(1, e);
    checks++; if (e !== 5) begin errors++; $display("[TB] FAIL early_1x8_latency got=%0d exp=5", e); end
    checks++; if (prodE !== 8'd8) begin errors++; $display("[TB] FAIL early_1x8_product got=%0d exp=8", prodE); end
    checks++; if (caE !== 5'd1 || cbE !== 5'd4) begin errors++; $display("[TB] FAIL early_1x8_cycles got=%0d/%0d exp=1/4", caE, cbE); end
    checks++; if (timeE !== 1'b1 || commE !== 1'b0) begin errors++; $display("[TB] FAIL early_1x8_flags time=%b comm=%b exp=1/0", timeE, commE); end
    checks++; if (errCntE !== 8'd1) begin errors++; $display("[TB] FAIL early_1x8_count got=%0d exp=1", errCntE); end
    @(posedge clk); #1;
    checks++; if (timeE !== 1'b0) begin errors++; $display("[TB] FAIL early_flag_clear got=%b exp=0", timeE); end
    applyStimulus(1, 4'd0, 4'd0, 1'b0);
    waitDone(1, e);
    checks++; if (e !== 2) begin errors++; $display("[TB] FAIL early_0x0_latency got=%0d exp=2", e); end
    checks++; if (prodE !== 8'd0 || caE !== 5'd1 || cbE !== 5'd1) begin errors++; $display("[TB] FAIL early_0x0 prod=%0d cyc=%0d/%0d exp=0 1/1", prodE, caE, cbE); end
    @(posedge clk); #1;
    applyStimulus(1, 4'd15, 4'd15, 1'b0);
    waitDone(1, e);
    checks++; if (e !== 5) begin errors++; $display("[TB] FAIL early_15x15_latency got=%0d exp=5", e); end
    checks++; if (prodE !== 8'd225 || caE !== 5'd4 || cbE !== 5'd4) begin errors++; $display("[TB] FAIL early_15x15 prod=%0d cyc=%0d/%0d exp=225 4/4", prodE, caE, cbE); end
    checks++; if (errCntE !== 8'd1) begin errors++; $display("[TB] FAIL early_count_hold got=%0d exp=1", errCntE); end
    @(posedge clk); #1;
  endtask

  task automatic test_fault_inject();
    int e;
    int extra;
    applyStimulus(0, 4'd6, 4'd7, 1'b1);
    fault_inj = 1'b0;
    @(posedge clk); #1;
    startC = 1'b1;
    @(posedge clk); #1;
    startC = 1'b0;
    waitDone(0, e);
    checks++; if (e !== 3) begin errors++; $display("[TB] FAIL fault_latency got=%0d exp=3 (after mid-run start)", e); end
    checks++; if (prodC !== 8'd42) begin errors++; $display("[TB] FAIL fault_product got=%0d exp=42", prodC); end
    checks++; if (commC !== 1'b1 || timeC !== 1'b0) begin errors++; $display("[TB] FAIL fault_flags comm=%b time=%b exp=1/0", commC, timeC); end
    checks++; if (errCntC !== 8'd1) begin errors++; $display("[TB] FAIL fault_count got=%0d exp=1", errCntC); end
    extra = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (doneC) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL fault_single_done extra=%0d exp=0", extra); end
  endtask

  task automatic test_reset_abort();
    int e;
    int seen;
    applyStimulus(0, 4'd3, 4'd5, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (readyC !== 1'b1 || doneC !== 1'b0) begin errors++; $display("[TB] FAIL abort_state ready=%b done=%b exp=1/0", readyC, doneC); end
    checks++; if (prodC !== 8'd0 || caC !== 5'd0 || cbC !== 5'd0 || errCntC !== 8'd0) begin errors++; $display("[TB] FAIL abort_zero prod=%0d ca=%0d cb=%0d cnt=%0d exp=0", prodC, caC, cbC, errCntC); end
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (doneC) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL abort_no_done got=%0d exp=0", seen); end
    applyStimulus(0, 4'd2, 4'd2, 1'b0);
    waitDone(0, e);
    checks++; if (e !== 5 || prodC !== 8'd4) begin errors++; $display("[TB] FAIL abort_rerun edges=%0d prod=%0d exp=5/4", e, prodC); end
    @(posedge clk); #1;
  endtask

  task automatic checkOutput(input int run, input logic [1:0] expCnt);
    int e;
    waitDone(2, e);
    checks++;
    if (e == 0 || errCntS !== expCnt || commS !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_run%0d edges=%0d cnt=%0d comm=%b exp cnt=%0d comm=1", run, e, errCntS, commS, expCnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] expTab [5];
    expTab = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    a = 4'd5; b = 4'd3; fault_inj = 1'b1; startS = 1'b1;
    for (int r = 0; r < 5; r++) checkOutput(r, expTab[r]);
    startS = 1'b0; fault_inj = 1'b0;
    checks++; if (prodS !== 8'd15) begin errors++; $display("[TB] FAIL sat_product got=%0d exp=15", prodS); end
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] starting mult_commute_checker bench");
    test_reset();
    test_const_time();
    test_early_exit();
    test_fault_inject();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
